// File: rtl/fir_stream.sv
// Streaming FIR filter: delay line, registered per-tap products and a saturating sum.
// All three stages advance together under one valid/ready backpressure signal.
module fir_stream #(
    parameter int DATA_W = 6,
    parameter int COEF_W = 4,
    parameter int NTAPS  = 8,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic signed [OUT_W-1:0]  m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_ovf,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     flush
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] x [NTAPS];
    logic signed [COEF_W-1:0] c [NTAPS];
    logic signed [PROD_W-1:0] p [NTAPS];
    logic                     d_valid;
    logic                     p_valid;
    logic                     advance;
    logic                     accept;
    logic                     addr_ok;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  sat_data;
    logic                     sat_ovf;

    // The whole pipeline moves whenever the output register is empty or being drained.
    assign advance  = !m_tvalid || m_tready;
    assign s_tready = advance;
    assign accept   = s_tvalid && advance;
    assign addr_ok  = 32'(coef_addr) < 32'(NTAPS);

    // Stage 0: delay line.
    // NOTE: sequential state uses <= so every register samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: these tap arrays are small flop banks, not RAM, so they can and must be reset.
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
            d_valid <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
            d_valid <= 1'b0;
        end else if (accept) begin
            x[0] <= s_tdata;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            d_valid <= 1'b1;
        end else if (advance) begin
            d_valid <= 1'b0;
        end
    end

    // Coefficients reload to an identity filter on reset; flush leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) c[k] <= (k == 0) ? COEF_W'(1) : '0;
        end else if (coef_we && addr_ok) begin
            c[coef_addr] <= coef_wdata;
        end
    end

    // Stage 1: full-width per-tap products.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) p[k] <= '0;
            p_valid <= 1'b0;
        end else if (flush) begin
            p_valid <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NTAPS; k++) p[k] <= PROD_W'(x[k]) * PROD_W'(c[k]);
            p_valid <= d_valid;
        end
    end

    // Sum is wide enough that it can never wrap; clipping happens only at the output.
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAPS; k++) sum = sum + ACC_W'(p[k]);
        sat_data = sum[OUT_W-1:0];
        sat_ovf  = 1'b0;
        if (sum > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end
    end

    // Stage 2: output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (flush) begin
            m_tvalid <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (advance) begin
            m_tdata  <= sat_data;
            m_ovf    <= sat_ovf;
            m_tvalid <= p_valid;
        end
    end
endmodule

// File: tb/tb_fir_stream.sv
// Self-checking bench for fir_stream: directed scenarios plus randomized streams,
// scored against an arithmetic FIR model driven by observed handshakes.
module tb_fir_stream;
    localparam int DATA_W = 6;
    localparam int COEF_W = 4;
    localparam int NTAPS  = 8;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = $clog2(NTAPS);

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] s_tdata;
    logic                     s_tvalid;
    logic                     s_tready;
    logic signed [OUT_W-1:0]  m_tdata;
    logic                     m_tvalid;
    logic                     m_tready;
    logic                     m_ovf;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     flush;

    fir_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_ovf(m_ovf),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: sample history, coefficients and the queue of expected results.
    int  model_coef [NTAPS];
    int  hist [NTAPS];
    int  exp_q [$];
    bit  exp_ovf_q [$];
    int  acc_step_q [$];
    int  got_q [$];
    bit  got_ovf_q [$];
    bit  check_lat;
    bit  bp_mode;
    int  stall_left;
    int  step_no;
    bit  prev_stall;
    logic signed [OUT_W-1:0] prev_data;
    logic prev_ovf;

    function automatic void model_reset_coefs();
        for (int k = 0; k < NTAPS; k++) model_coef[k] = (k == 0) ? 1 : 0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NTAPS; k++) hist[k] = 0;
        exp_q.delete();
        exp_ovf_q.delete();
        acc_step_q.delete();
    endfunction

    function automatic void model_accept(input int sample);
        int sum = 0;
        int hi = (1 << (OUT_W - 1)) - 1;
        int lo = -(1 << (OUT_W - 1));
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sample;
        for (int k = 0; k < NTAPS; k++) sum += hist[k] * model_coef[k];
        if (sum > hi) begin
            exp_q.push_back(hi);
            exp_ovf_q.push_back(1'b1);
        end else if (sum < lo) begin
            exp_q.push_back(lo);
            exp_ovf_q.push_back(1'b1);
        end else begin
            exp_q.push_back(sum);
            exp_ovf_q.push_back(1'b0);
        end
        acc_step_q.push_back(step_no);
    endfunction

    // One clock: called at a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick(output bit accepted);
        bit xfer;
        int e;
        bit eo;
        int as;
        if (bp_mode) begin
            if (stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
            end else begin
                m_tready = 1'($urandom_range(0, 1));
            end
        end
        #1;
        if (prev_stall) begin
            check("stall_hold_data", m_tdata, prev_data);
            check("stall_hold_valid", m_tvalid, 1);
            check("stall_hold_ovf", m_ovf, prev_ovf);
        end
        if (m_tvalid && !m_tready) check("stall_s_tready", s_tready, 0);
        accepted = s_tvalid && s_tready;
        xfer     = m_tvalid && m_tready;
        if (xfer) begin
            got_q.push_back(int'(m_tdata));
            got_ovf_q.push_back(m_ovf);
            if (exp_q.size() == 0) begin
                check("unexpected_output", exp_q.size(), 1);
            end else begin
                e  = exp_q.pop_front();
                eo = exp_ovf_q.pop_front();
                as = acc_step_q.pop_front();
                check("out_data", m_tdata, e);
                check("out_ovf", m_ovf, eo);
                if (check_lat) check("latency", step_no - as, 3);
            end
        end
        if (flush) model_clear();
        else if (accepted) model_accept(int'(s_tdata));
        if (coef_we && int'(coef_addr) < NTAPS) model_coef[coef_addr] = int'(coef_wdata);
        prev_stall = m_tvalid && !m_tready && !flush;
        prev_data  = m_tdata;
        prev_ovf   = m_ovf;
        step_no++;
        @(negedge clk);
    endtask

    task automatic idle();
        bit a;
        tick(a);
    endtask

    task automatic send(input int v);
        bit a = 1'b0;
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = DATA_W'(v);
        while (!a && n < 200) begin
            tick(a);
            n++;
        end
        s_tvalid = 1'b0;
        if (!a) check("send_accept", a, 1);
    endtask

    task automatic drain();
        int n = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() > 0 && n < 200) begin
            idle();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(a);
        coef_wdata = COEF_W'(v);
        idle();
        coef_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        idle();
        flush = 1'b0;
    endtask

    task automatic clear_got();
        got_q.delete();
        got_ovf_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1 [4] = '{5, -3, -32, 31};
        reset = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; flush = 1'b0;
        bp_mode = 1'b0; check_lat = 1'b1; stall_left = 0; step_no = 0; prev_stall = 1'b0;
        prev_data = '0; prev_ovf = 1'b0;
        model_reset_coefs();
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_ovf", m_ovf, 0);
        check("rst_s_tready", s_tready, 1);
        @(negedge clk);
        reset = 1'b1;

        // Identity after reset, back-to-back with fixed latency.
        clear_got();
        foreach (t1[i]) send(t1[i]);
        drain();
        check("t1_count", got_q.size(), 4);
        foreach (t1[i]) begin
            check("t1_out", got_q[i], t1[i]);
            check("t1_ovf", got_ovf_q[i], 0);
        end

        // Impulse response with all-ones, then k-4 coefficients.
        for (int pass = 0; pass < 2; pass++) begin
            do_flush();
            for (int k = 0; k < NTAPS; k++) write_coef(k, (pass == 0) ? 1 : k - 4);
            clear_got();
            send(10);
            for (int i = 0; i < 9; i++) send(0);
            drain();
            check("imp_count", got_q.size(), 10);
            for (int i = 0; i < 10; i++)
                check("imp_out", got_q[i], (i >= 8) ? 0 : ((pass == 0) ? 10 : 10 * (i - 4)));
        end

        // Saturation at both rails.
        for (int pass = 0; pass < 2; pass++) begin
            do_flush();
            for (int k = 0; k < NTAPS; k++) write_coef(k, (pass == 0) ? 7 : -8);
            clear_got();
            for (int i = 0; i < 8; i++) send(31);
            drain();
            check("sat_count", got_q.size(), 8);
            check("sat_out8", got_q[7], (pass == 0) ? 127 : -128);
            check("sat_ovf8", got_ovf_q[7], 1);
        end

        // Backpressure on a ramp with a forced 3-cycle stall.
        check_lat = 1'b0;
        do_flush();
        for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 15)) - 8);
        clear_got();
        bp_mode = 1'b1;
        for (int v = 1; v <= 20; v++) begin
            if (v == 6) stall_left = 3;
            send(v);
        end
        drain();
        bp_mode  = 1'b0;
        m_tready = 1'b1;
        check("bp_count", got_q.size(), 20);

        // Flush mid-stream together with a coefficient write; dropped sample 9.
        check_lat = 1'b1;
        do_flush();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 2);
        for (int v = 4; v <= 8; v++) send(v);
        check("pre_flush_valid", m_tvalid, 1);
        m_tready = 1'b0; flush = 1'b1; s_tvalid = 1'b1; s_tdata = DATA_W'(9);
        coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(3);
        idle();
        flush = 1'b0; s_tvalid = 1'b0; coef_we = 1'b0; m_tready = 1'b1;
        check("flush_valid", m_tvalid, 0);
        check("flush_ovf", m_ovf, 0);
        clear_got();
        send(10);
        for (int i = 0; i < 7; i++) send(0);
        drain();
        check("flush_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check("flush_imp", got_q[i], (i == 0) ? 30 : 20);

        // Randomized stream with gaps and random backpressure.
        check_lat = 1'b0;
        do_flush();
        for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 15)) - 8);
        clear_got();
        bp_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(int'($urandom_range(0, 63)) - 32);
        end
        drain();
        bp_mode  = 1'b0;
        check("rand_count", got_q.size(), 40);

        // Asynchronous reset with data stalled in flight and coefficients loaded.
        m_tready = 1'b1;
        do_flush();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
        m_tready = 1'b0;
        for (int v = 1; v <= 3; v++) send(v);
        idle();
        check("pre_reset_valid", m_tvalid, 1);
        #2 reset = 1'b0;
        #1;
        check("areset_valid", m_tvalid, 0);
        check("areset_data", m_tdata, 0);
        check("areset_ovf", m_ovf, 0);
        check("areset_s_tready", s_tready, 1);
        model_clear();
        model_reset_coefs();
        prev_stall = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        m_tready = 1'b1;
        check_lat = 1'b1;
        clear_got();
        send(7);
        send(3);
        drain();
        check("post_reset_count", got_q.size(), 2);
        check("post_reset_7", got_q[0], 7);
        check("post_reset_3", got_q[1], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_stream.md
# fir_stream

Parametrised streaming FIR filter for the signal path: signed samples enter on a valid/ready input port, pass through an NTAPS-deep delay line, multiply by runtime-loadable coefficients, and leave as saturated signed results on a valid/ready output port. It replaces fixed-tap, fixed-width filter instances and supports backpressure, coefficient reload, flush and overflow reporting.

## Interface
- DATA_W, 6: input sample width, signed two's complement
- COEF_W, 4: coefficient width, signed
- NTAPS, 8: tap count, 2..32
- OUT_W, 8: output width, signed, saturated
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- s_tdata  in  DATA_W  input sample
- s_tvalid  in  1  input sample valid
- s_tready  out  1  filter can accept; combinational
- m_tdata  out  OUT_W  filtered output
- m_tvalid  out  1  m_tdata valid
- m_tready  in  1  downstream accepts
- m_ovf  out  1  current m_tdata was saturated; qualified by m_tvalid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index to write
- coef_wdata  in  COEF_W  coefficient value
- flush  in  1  synchronous clear of delay line and pipeline

## Operation
- Handshakes: input accept = s_tvalid & s_tready; output transfer = m_tvalid & m_tready.
- advance = !m_tvalid | m_tready; s_tready = advance. All pipeline stages move only when advance is high.
- Stage 0, delay line: on accept, x[0] <= s_tdata and x[k] <= x[k-1] for k = 1..NTAPS-1; d_valid <= 1. On advance without accept, d_valid <= 0 and the delay line holds.
- Stage 1, products: on advance, p[k] <= x[k]*c[k] at full width DATA_W+COEF_W; p_valid <= d_valid.
- Stage 2, output: on advance, the sum of all p[k] is formed at ACC_W = DATA_W+COEF_W+clog2(NTAPS) with no internal overflow, then saturated to OUT_W.
  - m_tdata <= saturated sum; m_ovf <= 1 if clipped; m_tvalid <= p_valid.
  - Saturation limits are 2^(OUT_W-1)-1 and -2^(OUT_W-1).
- No warm-up gating: the delay line starts at zero, so the first outputs reflect zero history.
- Coefficients:
  - On coef_we with coef_addr < NTAPS, c[coef_addr] <= coef_wdata at that edge.
  - Writes with coef_addr >= NTAPS are ignored.
  - Writes are allowed while streaming and affect products registered on later edges.
- flush:
  - Clears x[], d_valid, p_valid, m_tvalid and m_ovf at the next edge.
  - Takes priority over a same-cycle accept; that sample is dropped, and s_tready stays as computed.
  - Coefficients are untouched.
  - A flush and a coef write in the same cycle both take effect.

## Timing
- Reset (async assert, sync release):
  - x[] = 0, all valids = 0.
  - c[0] = 1, c[1..NTAPS-1] = 0, so the filter is an identity.
  - m_tdata = 0, m_tvalid = 0, m_ovf = 0.
  - s_tready = 1 after reset, since m_tvalid = 0.
- Latency: a sample accepted at edge N appears on m_tdata/m_tvalid after edge N+2 when not stalled.
- Throughput: one sample per clock while m_tready = 1.
- Stall: while m_tvalid = 1 and m_tready = 0, m_tdata, m_ovf and all stage registers hold, and s_tready = 0.
- A new result may load on the same edge that the current one transfers.
- Reset mid-operation discards all in-flight samples and reloads the default coefficients.

## Test plan
- Reset defaults: after reset release, send samples 5, -3, -32, 31 back-to-back with m_tready = 1. Outputs must be 5, -3, -32, 31, each 2 cycles after its accept, with m_ovf = 0.
- Impulse response: write all 8 coefficients = 1, then feed 10 followed by 9 zeros. Outputs must be 10 eight times, then 0. Repeat with coefficients k-4 for k = 0..7: outputs must be -40, -30, -20, -10, 0, 10, 20, 30.
- Saturation: all coefficients 7 and eight inputs of 31 must give an eighth output of 127 with m_ovf = 1 (raw sum 1736). All coefficients -8 and inputs of 31 must give -128 with m_ovf = 1.
- Backpressure: stream a ramp 1..20 with m_tready toggled randomly, including a 3-cycle low. Require:
  - m_tdata stable while stalled and s_tready low during the stall;
  - the output sequence exactly equals the golden model, with no loss or duplication.
- Flush: assert flush mid-stream while m_tvalid = 1. m_tvalid must be 0 the next cycle, and a subsequent impulse of 10 must produce an output with zero history (first output 10·c[0]).
- Async reset with data in flight and c[] loaded: outputs must clear immediately, c[] must return to the identity, and the next input 7 must produce 7.
